// File: rtl/uart_word_tx.sv
// uart_word_tx: UART transmitter for 1..BYTES_MAX-byte words.
// A word is accepted through a valid/ready handshake and is sent as back-to-back
// 8N1 frames with no idle gap between bytes. Byte order is selected by MSB_FIRST.
// o_byte_done pulses as each frame ends. o_done pulses as the word ends.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after the data
// bits. The parity sense is set by PARITY_ODD (0 even, 1 odd).
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int BYTES_MAX    = 4,
    parameter int MSB_FIRST    = 1,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                         sys_clk,
    input  logic                         sw_0,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [8*BYTES_MAX-1:0]       i_data,
    input  logic [$clog2(BYTES_MAX):0]   i_nbytes,
    output logic                         o_serial,
    output logic                         o_busy,
    output logic                         o_byte_done,
    output logic                         o_done
);

    localparam int NB_W  = $clog2(BYTES_MAX) + 1;
    localparam int IDX_W = (BYTES_MAX > 1) ? $clog2(BYTES_MAX) : 1;
    localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT + 1);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [NB_W-1:0]  NB_MAX   = NB_W'(BYTES_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NB_W-1:0]        rem_q, rem_d;
    logic [8*BYTES_MAX-1:0] word_q, word_d;
    logic                   done_q, done_d;
    logic                   bdone_q, bdone_d;

    logic [NB_W-1:0]        nb_clamp;
    logic [NB_W-1:0]        nb_m1;
    logic [7:0]             cur_byte;

    // Requests larger than the word width are clamped to a full word.
    assign nb_clamp = (i_nbytes > NB_MAX) ? NB_MAX : i_nbytes;
    assign nb_m1    = nb_clamp - NB_W'(1);
    assign cur_byte = word_q[{idx_q, 3'b000} +: 8];

    // State and counter registers. Reset aborts any frame in flight.
    always_ff @(posedge sys_clk or negedge sw_0) begin
        if (!sw_0) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
            bdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            word_q  <= word_d;
            done_q  <= done_d;
            bdone_q <= bdone_d;
        end
    end

    // Next-state logic. baud_q restarts at every bit boundary, so timing cannot drift across bytes.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        word_d  = word_q;
        done_d  = 1'b0;
        bdone_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    word_d = i_data;
                    if (nb_clamp == '0) begin
                        done_d = 1'b1;
                    end else begin
                        rem_d   = nb_clamp;
                        idx_d   = (MSB_FIRST != 0) ? nb_m1[IDX_W-1:0] : '0;
                        baud_d  = '0;
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                if (baud_q == BIT_END) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (baud_q == BIT_END) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_q == BIT_END) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (baud_q == STOP_END) begin
                    baud_d  = '0;
                    bdone_d = 1'b1;
                    rem_d   = rem_q - NB_W'(1);
                    if (rem_q == NB_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        // Zero gap between bytes: the next start bit begins on the next cycle.
                        idx_d   = (MSB_FIRST != 0) ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
                        state_d = S_START;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line driver. The line is decoded from the state, so reset forces it high at once.
    always_comb begin
        o_serial = 1'b1;
        case (state_q)
            S_START:  o_serial = 1'b0;
            S_DATA:   o_serial = cur_byte[bit_q];
`ifdef UART_TX_PARITY_EN
            S_PARITY: o_serial = (^cur_byte) ^ (PARITY_ODD != 0);
`endif
            default:  o_serial = 1'b1;
        endcase
    end

    assign o_ready     = (state_q == S_IDLE);
    assign o_busy      = (state_q != S_IDLE);
    assign o_byte_done = bdone_q;
    assign o_done      = done_q;

endmodule
